// File: rtl/axis_bram_job_scheduler.sv
// axis_bram_job_scheduler
// Sequences the AXI-S/BRAM adapter one job at a time from a small command FIFO.
// The adapter is held in reset (adapter_rstn low) except while a job is in RUN.
// rw/start/bound are driven from job registers that only change when a command
// is popped. Each finished job produces one tagged status word.

module axis_bram_job_scheduler #(
    parameter int BRAM_DEPTH     = 12,
    parameter int QUEUE_DEPTH    = 4,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                          clk,
    input  logic                          rst,
    // command queue
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic                          cmd_rw,
    input  logic [BRAM_DEPTH-1:0]         cmd_start_addr,
    input  logic [BRAM_DEPTH-1:0]         cmd_bound_addr,
    input  logic [3:0]                    cmd_tag,
    // adapter controller configuration
    output logic                          rw,
    output logic [BRAM_DEPTH-1:0]         bram_start_addr,
    output logic [BRAM_DEPTH-1:0]         bram_bound_addr,
    output logic                          adapter_rstn,
    // monitored adapter BRAM port
    input  logic                          bram_en,
    input  logic                          bram_wen,
    input  logic [BRAM_DEPTH-1:0]         bram_addr,
    // monitored adapter master stream
    input  logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    input  logic                          m_axis_tlast,
    // status
    output logic                          sts_valid,
    input  logic                          sts_ready,
    output logic [3:0]                    sts_tag,
    output logic                          sts_rw,
    output logic [1:0]                    sts_err,
    output logic                          busy,
    output logic [$clog2(QUEUE_DEPTH):0]  queue_level
);

    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(QUEUE_DEPTH);
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [WD_W-1:0]  WD_MAX   = WD_W'(TIMEOUT_CYCLES);

    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_TIMEOUT = 2'b01;
    localparam logic [1:0] ERR_RANGE   = 2'b10;

    typedef struct packed {
        logic                  rw;
        logic [BRAM_DEPTH-1:0] start;
        logic [BRAM_DEPTH-1:0] bound;
        logic [3:0]            tag;
    } cmd_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DRAIN,
        S_REPORT
    } state_t;

    // ------------------------------------------------------------------
    // Command FIFO
    // ------------------------------------------------------------------
    cmd_t              fifo_q [QUEUE_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q,  level_d;
    logic              full, empty, push, pop;
    cmd_t              cmd_in;

    assign full      = (level_q == LVL_FULL);
    assign empty     = (level_q == '0);
    assign cmd_ready = !full && !rst;
    assign push      = cmd_valid && cmd_ready;

    assign cmd_in.rw    = cmd_rw;
    assign cmd_in.start = cmd_start_addr;
    assign cmd_in.bound = cmd_bound_addr;
    assign cmd_in.tag   = cmd_tag;

    // Pointer and level next-state; pointers wrap naturally (power-of-two depth)
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (push && !pop)      level_d = level_q + LVL_W'(1);
        else if (pop && !push) level_d = level_q - LVL_W'(1);
    end

    // FIFO pointer/level registers; reset flushes the queue
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Entry storage; only written on push, validity is tracked by the level
    always_ff @(posedge clk) begin
        if (push) fifo_q[wr_ptr_q] <= cmd_in;
    end

    // ------------------------------------------------------------------
    // Job FSM
    // ------------------------------------------------------------------
    state_t            state_q, state_d;
    cmd_t              job_q,   job_d;
    logic [1:0]        err_q,   err_d;
    logic [WD_W-1:0]   wd_q,    wd_d;
    logic              adapter_rstn_q;
    logic              wr_done, rd_done, done;

    // Completion depends on the job direction: a write finishes when the
    // bound index is written, a read finishes on the last beat handed out.
    assign wr_done = bram_en && bram_wen && (bram_addr == job_q.bound);
    assign rd_done = m_axis_tvalid && m_axis_tready && m_axis_tlast;
    assign done    = job_q.rw ? wr_done : rd_done;

    // Next-state, pop request, job/watchdog/error updates
    always_comb begin
        state_d = state_q;
        job_d   = job_q;
        err_d   = err_q;
        wd_d    = wd_q;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    job_d   = fifo_q[rd_ptr_q];
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (job_q.start > job_q.bound) begin
                    err_d   = ERR_RANGE;
                    state_d = S_REPORT;
                end else begin
                    wd_d    = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                // saturating watchdog; it is reloaded in LOAD so it never wraps
                if (wd_q != WD_MAX) wd_d = wd_q + WD_W'(1);
                if (done) begin
                    err_d   = ERR_OK;
                    state_d = S_DRAIN;
                end else if (wd_q == WD_LAST) begin
                    err_d   = ERR_TIMEOUT;
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                state_d = S_REPORT;
            end
            S_REPORT: begin
                if (sts_ready) state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // FSM and job registers; adapter_rstn is registered so it is glitch-free
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            job_q          <= '0;
            err_q          <= ERR_OK;
            wd_q           <= '0;
            adapter_rstn_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            job_q          <= job_d;
            err_q          <= err_d;
            wd_q           <= wd_d;
            adapter_rstn_q <= (state_d == S_RUN);
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign rw              = job_q.rw;
    assign bram_start_addr = job_q.start;
    assign bram_bound_addr = job_q.bound;
    assign adapter_rstn    = adapter_rstn_q;

    assign sts_valid   = (state_q == S_REPORT);
    assign sts_tag     = job_q.tag;
    assign sts_rw      = job_q.rw;
    assign sts_err     = err_q;
    assign busy        = (state_q != S_IDLE);
    assign queue_level = level_q;

endmodule

// File: doc/axis_bram_job_scheduler.md
# axis_bram_job_scheduler

Job scheduler that sequences the AXI-S/BRAM adapter datapath from a queue of transfer commands. Each command is a direction, a BRAM start index and a bound index. The scheduler holds the adapter controller in reset between jobs and presents stable `rw`/start/bound values. It releases the adapter to run one job, detects completion or timeout, re-parks the adapter, and reports a tagged status word. It replaces the static `rw`/`bram_start_addr`/`bram_bound_addr` tie-offs used in the test top level.

## Interface
Parameters:
- `BRAM_DEPTH`, 12: BRAM index width.
- `QUEUE_DEPTH`, 4: command FIFO entries; power of two, ≥2.
- `TIMEOUT_CYCLES`, 65535: maximum RUN cycles per job, ≥2.

Ports:
- `clk` in 1: single clock, shared with `s00_axis_aclk`.
- `rst` in 1: synchronous, active-high reset.
- `cmd_valid` in 1, `cmd_ready` out 1: command handshake.
- `cmd_rw` in 1: 1 = stream-in to BRAM (write job), 0 = BRAM read-back to stream (read job).
- `cmd_start_addr` in BRAM_DEPTH; `cmd_bound_addr` in BRAM_DEPTH; `cmd_tag` in 4.
- `rw` out 1; `bram_start_addr` out BRAM_DEPTH; `bram_bound_addr` out BRAM_DEPTH: to the adapter controller.
- `adapter_rstn` out 1: active-low reset to the adapter controller and the S/M AXIS interfaces.
- `bram_en`, `bram_wen` in 1; `bram_addr` in BRAM_DEPTH: monitored adapter BRAM port.
- `m_axis_tvalid`, `m_axis_tready`, `m_axis_tlast` in 1: monitored adapter master stream.
- `sts_valid` out 1, `sts_ready` in 1: status handshake.
- `sts_tag` out 4; `sts_rw` out 1; `sts_err` out 2: 00 ok, 01 timeout, 10 bad range.
- `busy` out 1: high in any state other than IDLE.
- `queue_level` out clog2(QUEUE_DEPTH)+1: number of FIFO entries.

## Operation
- Command FIFO:
  - `cmd_ready = !full && !rst`. A push occurs when `cmd_valid && cmd_ready`.
  - A pop occurs only from IDLE. Push and pop in the same cycle are both honoured, and the level is unchanged.
- FSM states: IDLE, LOAD, RUN, DRAIN, REPORT.
- IDLE:
  - If the FIFO is not empty, pop the head into job registers (rw_q, start_q, bound_q, tag_q) and go to LOAD.
  - Otherwise stay in IDLE.
- LOAD (1 cycle):
  - Outputs `rw`/`bram_start_addr`/`bram_bound_addr` already reflect the job registers; `adapter_rstn` = 0.
  - If start_q > bound_q (unsigned), set err=10 and go to REPORT, skipping RUN and DRAIN.
  - Otherwise clear the watchdog and go to RUN.
- RUN:
  - `adapter_rstn` = 1; the watchdog increments each cycle.
  - Write-job done: `bram_en && bram_wen && bram_addr == bound_q`.
  - Read-job done: `m_axis_tvalid && m_axis_tready && m_axis_tlast`.
  - On done, set err=00 and go to DRAIN.
  - If the watchdog equals TIMEOUT_CYCLES-1 and there is no done that cycle, set err=01 and go to DRAIN.
  - Done and timeout in the same cycle: done wins.
- DRAIN (1 cycle): `adapter_rstn` = 0, then go to REPORT.
- REPORT:
  - `sts_valid` = 1, carrying tag_q, rw_q and err.
  - On `sts_ready`, go to IDLE.
  - Status fields hold stable while `sts_valid && !sts_ready`.
- Job outputs `rw`/`bram_start_addr`/`bram_bound_addr` change only on a pop. They are stable from LOAD through REPORT.
- Watchdog width is clog2(TIMEOUT_CYCLES+1). It saturates and never wraps.
- FIFO pointers wrap modulo QUEUE_DEPTH.

## Timing
- Reset values:
  - `cmd_ready` = 0 while `rst` = 1.
  - `adapter_rstn` = 0, `sts_valid` = 0, `busy` = 0, `queue_level` = 0.
  - `rw` = 0, addresses = 0, `sts_tag`/`sts_rw`/`sts_err` = 0.
  - FIFO is flushed.
- Reset mid-job: the FSM returns to IDLE on the next edge, `adapter_rstn` goes low, and queued and in-flight commands are discarded with no status.
- Latency, command accepted at edge N into an empty FIFO with the FSM in IDLE:
  - Pop and LOAD at N+1.
  - RUN (`adapter_rstn` high) at N+2.
- Completion detected at edge M: DRAIN at M+1, `sts_valid` high at M+2.
- Back-to-back jobs: the next pop occurs at the edge after the `sts_ready` handshake. The adapter sees at least 2 reset cycles (DRAIN + LOAD) between jobs.
- When full, `cmd_ready` = 0. It rises the cycle after a pop.

## Test plan
- Single write job (rw=1, start=0, bound=3, tag=5); the bench models the adapter asserting `bram_en&wen` at addrs 0..3 -> `adapter_rstn` high from N+2, DRAIN after the addr-3 write, status {tag=5, rw=1, err=00}.
- Read job (rw=0, start=2, bound=4, tag=9); `m_axis_tlast` handshake at cycle 40 of RUN -> status err=00 two cycles later; `bram_start_addr`=2 and `bram_bound_addr`=4 stable throughout.
- Bad range (start=7, bound=3, tag=1) -> `adapter_rstn` never rises; `sts_valid` two cycles after accept with err=10.
- TIMEOUT_CYCLES=16, read job with no tlast -> exactly 16 RUN cycles, then DRAIN, then err=01; the next queued job starts normally. A tlast on cycle 16 yields err=00.
- Push 5 commands with QUEUE_DEPTH=4 and `sts_ready`=0 -> `cmd_ready` drops after the 5th push (4 queued + 1 in job); statuses emerge in tag order once `sts_ready` is asserted; `queue_level` counts back down to 0.
- Assert `rst` during RUN with 2 commands queued -> next cycle IDLE, `adapter_rstn`=0, `queue_level`=0, no `sts_valid`.
